mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator-side engine for the single-port 16-bit word memory.
- Drives the memory's write strobe, address and write-data lines, and reads its combinational read-data output.
- Copies a block of LENGTH words from a source address to a destination address.
- Sits between the control unit (start/done handshake) and the memory port; owns the port exclusively while busy.

Parameters:
- ADDR_WIDTH, 16, width of memory address, source/destination addresses and length.
- DATA_WIDTH, 16, width of memory word.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a copy; sampled only in IDLE.
- srcAddr  input  ADDR_WIDTH  first source word address, latched on accepted start.
- dstAddr  input  ADDR_WIDTH  first destination word address, latched on accepted start.
- length  input  ADDR_WIDTH  number of words to copy, latched on accepted start; 0 is legal.
- busy  output  1  high while the copy is in progress (READ/WRITE states).
- done  output  1  one-cycle completion pulse.
- memWrite  output  1  memory write strobe, level-sensitive at the memory.
- memAddress  output  ADDR_WIDTH  memory address.
- memWriteData  output  DATA_WIDTH  memory write data.
- memData  input  DATA_WIDTH  memory read data, combinational from memAddress.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, memWrite=0, memAddress=0, memWriteData=0; internal src/dst/count/buffer registers cleared to 0.
- All outputs are registered or decoded from the state register only, so memWrite is glitch-free.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 and length!=0 -> latch srcAddr/dstAddr/length, go to READ.
  - start=1 and length=0 -> go to DONE; no memory access.
  - Otherwise stay in IDLE.
- READ:
  - memWrite=0, memAddress=src.
  - At the edge, capture memData into buffer and go to WRITE.
- WRITE:
  - memWrite=1, memAddress=dst, memWriteData=buffer.
  - Address and data stay stable for the whole cycle.
  - At the edge: src+=1, dst+=1, count-=1.
  - count was 1 -> go to DONE; else go to READ.
- DONE:
  - done=1, busy=0, memWrite=0 for exactly one cycle, then IDLE.
- Timing: start accepted at edge T with length N>0 -> busy=1 for cycles T+1..T+2N, done=1 in cycle T+2N+1. Throughput is 2 cycles/word.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000; no error is raised.
- Overlap: the copy is ascending, word by word. Overlapping ranges with dst>src propagate already-written words; this is defined behaviour and is not corrected.
- start while busy or in DONE is ignored; no queuing.
- Reset mid-copy: the next edge returns to IDLE with memWrite=0 and no done pulse. Words already written stay written.
- Reset and start asserted in the same cycle: reset wins.
- memAddress in IDLE/DONE holds its last value; memWrite is always 0 outside WRITE.

Optional Feature:
- Macro: MEM_COPY_FILL_EN.
- Defined:
  - Adds input ports fillMode (1 bit) and fillValue (DATA_WIDTH), both latched on accepted start.
  - With fillMode=1 the engine skips READ and goes IDLE->WRITE->WRITE...->DONE, writing fillValue to N consecutive dst addresses.
  - Fill throughput is 1 cycle/word; done arrives in cycle T+N+1.
  - srcAddr is ignored in fill mode.
- Not defined:
  - Ports fillMode and fillValue do not exist; the engine is copy-only as above.

Test Plan:
- Preload mem[0x0010..0x0012]=0xAAAA,0xBBBB,0xCCCC; start src=0x0010 dst=0x0100 len=3 -> busy for 6 cycles, done pulse in cycle 7, mem[0x0100..0x0102] match the source, source unchanged.
- start len=0 -> done=1 the cycle after start, busy never 1, memWrite never 1.
- Wrap: src=0xFFFE dst=0xFFFF len=3 with mem[0xFFFE]=0x1234, mem[0xFFFF]=0x00FF, mem[0x0000]=0x5678 -> writes go to 0xFFFF, 0x0000, 0x0001 with propagated data 0x1234, 0x1234, 0x1234 (overlap case).
- Assert reset in the 3rd busy cycle of len=4 copy -> IDLE next edge, memWrite=0, no done pulse, only the first destination word written; a new start then completes normally.
- Pulse start again during busy with different addresses -> ignored; original copy completes with the original parameters and a single done pulse.
- With MEM_COPY_FILL_EN: fillMode=1 fillValue=0xBEEF dst=0x0200 len=4 -> memWrite high for 4 consecutive cycles, mem[0x0200..0x0203]=0xBEEF, done in cycle 5.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block copy engine for a single-port word memory; optional fill mode under MEM_COPY_FILL_EN.
// Latency: 2 cycles/word copy (1 cycle/word fill), done pulse one cycle after the last write.
// Backpressure: none; start is only honoured in IDLE, the memory port is owned while busy.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddr,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic [ADDR_WIDTH-1:0] length,
`ifdef MEM_COPY_FILL_EN
  input  logic                  fillMode,
  input  logic [DATA_WIDTH-1:0] fillValue,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] buffer;

`ifdef MEM_COPY_FILL_EN
  logic fill;
`else
  localparam logic fill = 1'b0;
`endif

  // The data buffer is the write-data register, so data is stable for the whole WRITE cycle.
  assign memWriteData = buffer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      memWrite   <= 1'b0;
      memAddress <= '0;
      src        <= '0;
      dst        <= '0;
      count      <= '0;
      buffer     <= '0;
`ifdef MEM_COPY_FILL_EN
      fill       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              src   <= srcAddr;
              dst   <= dstAddr;
              count <= length;
              busy  <= 1'b1;
`ifdef MEM_COPY_FILL_EN
              fill  <= fillMode;
              if (fillMode) begin
                buffer     <= fillValue;
                memWrite   <= 1'b1;
                memAddress <= dstAddr;
                state      <= WRITE;
              end else begin
                memAddress <= srcAddr;
                state      <= READ;
              end
`else
              memAddress <= srcAddr;
              state      <= READ;
`endif
            end
          end
        end
        READ: begin
          buffer     <= memData;
          memWrite   <= 1'b1;
          memAddress <= dst;
          state      <= WRITE;
        end
        WRITE: begin
          src   <= src + ADDR_WIDTH'(1);
          dst   <= dst + ADDR_WIDTH'(1);
          count <= count - ADDR_WIDTH'(1);
          if (count == ADDR_WIDTH'(1)) begin
            memWrite <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (fill) begin
            memAddress <= dst + ADDR_WIDTH'(1);
          end else begin
            memWrite   <= 1'b0;
            memAddress <= src + ADDR_WIDTH'(1);
            state      <= READ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: memory model plus a word-by-word reference copy of the whole memory.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] srcAddr;
  logic [15:0] dstAddr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        memWrite;
  logic [15:0] memAddress;
  logic [15:0] memWriteData;
  logic [15:0] memData;
`ifdef MEM_COPY_FILL_EN
  logic        fillMode;
  logic [15:0] fillValue;
`endif

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .srcAddr(srcAddr),
    .dstAddr(dstAddr),
    .length(length),
`ifdef MEM_COPY_FILL_EN
    .fillMode(fillMode),
    .fillValue(fillValue),
`endif
    .busy(busy),
    .done(done),
    .memWrite(memWrite),
    .memAddress(memAddress),
    .memWriteData(memWriteData),
    .memData(memData)
  );

  assign memData = mem[memAddress];

  always @(posedge clk) begin
    if (memWrite === 1'b1) mem[memAddress] = memWriteData;
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 65536; a++)
      if (mem[a] !== ref_mem[a]) bad++;
    check(bad, 0, {tag, "/mem_words_wrong"});
  endtask

  // Issues one operation at a negedge and measures busy/write/done timing until done or timeout.
  task automatic run_op(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                        input logic fm, input logic [15:0] fv, input bit poke, input string tag);
    int per, cyc, busy_cnt, wr_cnt, done_cyc, extra;
    logic [15:0] a_s, a_d;
    per = fm ? 1 : 2;
    srcAddr = s; dstAddr = d; length = l; start = 1'b1;
`ifdef MEM_COPY_FILL_EN
    fillMode = fm; fillValue = fv;
`endif
    @(negedge clk);
    start = 1'b0; cyc = 1; busy_cnt = 0; wr_cnt = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc <= per * int'(l) + 4) begin
      if (busy === 1'b1) busy_cnt++;
      if (memWrite === 1'b1) wr_cnt++;
      if (done === 1'b1) done_cyc = cyc;
      start = poke && (cyc == 2 || done_cyc != 0);
      if (start) begin
        srcAddr = 16'($urandom); dstAddr = 16'($urandom); length = 16'($urandom_range(1, 5));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) extra++;
      if (busy === 1'b1) extra++;
      if (memWrite === 1'b1) extra++;
      @(negedge clk);
    end
    check(busy_cnt, per * int'(l), {tag, "/busy_cycles"});
    check(wr_cnt, int'(l), {tag, "/write_cycles"});
    check(done_cyc, per * int'(l) + 1, {tag, "/done_cycle"});
    check(extra, 0, {tag, "/activity_after_done"});
    for (int i = 0; i < int'(l); i++) begin
      a_s = s + 16'(i);
      a_d = d + 16'(i);
      ref_mem[a_d] = fm ? fv : ref_mem[a_s];
    end
    check_mem(tag);
  endtask

  initial begin
    logic [15:0] s, d, l;
    reset = 1'b1; start = 1'b0; srcAddr = '0; dstAddr = '0; length = '0;
`ifdef MEM_COPY_FILL_EN
    fillMode = 1'b0; fillValue = '0;
`endif
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    repeat (2) @(negedge clk);
    check(busy, 0, "rst/busy");
    check(done, 0, "rst/done");
    check(memWrite, 0, "rst/memWrite");
    check(memAddress, 0, "rst/memAddress");
    check(memWriteData, 0, "rst/memWriteData");
    reset = 1'b0;
    @(negedge clk);

    preload(16'h0010, 16'hAAAA); preload(16'h0011, 16'hBBBB); preload(16'h0012, 16'hCCCC);
    run_op(16'h0010, 16'h0100, 16'd3, 1'b0, 16'h0, 1'b0, "copy3");
    check(mem[16'h0102], 16'hCCCC, "copy3/last_word");

    run_op(16'h0020, 16'h0030, 16'd0, 1'b0, 16'h0, 1'b0, "len0");

    preload(16'hFFFE, 16'h1234); preload(16'hFFFF, 16'h00FF); preload(16'h0000, 16'h5678);
    run_op(16'hFFFE, 16'hFFFF, 16'd3, 1'b0, 16'h0, 1'b0, "wrap");
    check(mem[16'h0000], 16'h1234, "wrap/word_0000");
    check(mem[16'h0001], 16'h1234, "wrap/word_0001");

    run_op(16'h0040, 16'h0500, 16'd5, 1'b0, 16'h0, 1'b1, "start_while_busy");

    // Reset lands in the third busy cycle (second READ): only word 0 has been written.
    srcAddr = 16'h0060; dstAddr = 16'h0600; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check(busy, 1, "rst_mid/busy_before");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check(busy, 0, "rst_mid/busy");
    check(memWrite, 0, "rst_mid/memWrite");
    check(done, 0, "rst_mid/done");
    @(negedge clk);
    check(done, 0, "rst_mid/no_done_later");
    ref_mem[16'h0600] = ref_mem[16'h0060];
    check_mem("rst_mid");
    run_op(16'h0070, 16'h0700, 16'd4, 1'b0, 16'h0, 1'b0, "after_rst");

    reset = 1'b1; start = 1'b1; srcAddr = 16'h0080; dstAddr = 16'h0800; length = 16'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check(busy, 0, "rst_and_start/busy");
    @(negedge clk);
    check(busy | done | memWrite, 0, "rst_and_start/idle");

    for (int i = 0; i < 8; i++) begin
      s = 16'($urandom);
      d = (i % 2 == 0) ? s + 16'($urandom_range(1, 4)) : 16'($urandom);
      l = 16'($urandom_range(1, 12));
      run_op(s, d, l, 1'b0, 16'h0, (i % 3 == 0), "random_copy");
    end

`ifdef MEM_COPY_FILL_EN
    run_op(16'h0000, 16'h0200, 16'd4, 1'b1, 16'hBEEF, 1'b0, "fill4");
    check(mem[16'h0203], 16'hBEEF, "fill4/last_word");
    for (int i = 0; i < 4; i++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom_range(1, 10)), 1'b1,
             16'($urandom), 1'b0, "random_fill");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
